pixel_data: RTL and testbench
=============================

// Module: pixel_data
// PURPOSE
// - Circular byte buffer holding one 72-pixel window of the digit image between the SPI receiver and the network.
// - SPI loads bytes at the tail; the network rotates the ring and reads the two oldest bytes at the head each cycle.
// - Contents recirculate, so the network can make repeated passes over the same pixels without reloading.
// PARAMETERS
// - DEPTH  72  number of byte entries in the ring (>=2)
// - WIDTH  8   bits per entry
// PORTS
// Interface: one clock; reset is asynchronous and active-low.
// - clk            in   1      system clock, rising-edge
// - n_rst          in   1      asynchronous active-low reset
// - shift_SPI      in   1      advance ring one entry (SPI load strobe)
// - shift_network  in   1      advance ring one entry (network read strobe)
// - write_en       in   1      on a shift, load spi_in at tail instead of recirculating
// - spi_in         in   WIDTH  byte to load
// - pixel_data_1   out  WIDTH  entry [1] (second oldest)
// - pixel_data_2   out  WIDTH  entry [0] (head, oldest)
// BEHAVIOUR
// - Storage mem[0..DEPTH-1]: mem[0] is head, mem[DEPTH-1] is tail.
// - Reset (n_rst=0, asynchronous): all entries 0, so both outputs read 0; `wrap` (optional) is 0.
// - shift = shift_SPI | shift_network. Asserting both in one cycle gives exactly ONE shift.
// - On rising clk with shift=1: mem[i] <= mem[i+1] for i=0..DEPTH-2;
//   mem[DEPTH-1] <= write_en ? spi_in : mem[0] (wrap-around recirculation).
// - shift=0: hold all entries; write_en alone has no effect.
// - Outputs are combinational from registers: pixel_data_1 = mem[1], pixel_data_2 = mem[0].
// - Outputs update in the same cycle as the shift edge; there is no handshake and no pipeline latency.
// - A byte loaded at the tail reaches the head after DEPTH-1 further shifts.
// - DEPTH consecutive recirculating shifts restore the original contents exactly.
// - There is no full/empty tracking: loading always overwrites the oldest entry.
// - Reset asserted mid-operation clears everything immediately; the in-flight shift is lost.
// CONFIGURATION
// - Macro PIXEL_DATA_POSITION_EN.
// - When defined, add outputs:
//   - position [$clog2(DEPTH)-1:0]: counts shifts mod DEPTH; 0 at reset; increments on each shift; wraps DEPTH-1 -> 0.
//   - wrap [1]: registered pulse, high for one cycle after the shift that takes position from DEPTH-1 to 0.
// - When not defined, these ports and their logic do not exist; ring behaviour is identical either way.
// TESTING
// - Zero fill: write_en=1, spi_in=0, shift_network=1 for 140 cycles -> pixel_data_1=0x00, pixel_data_2=0x00.
// - Two-byte travel: shift_SPI+write_en with 0xFF then 0xAA, then 70 network shifts
//   -> pixel_data_1=0xAA, pixel_data_2=0xFF.
// - Full load: shift_SPI+write_en with spi_in=0..71 over 72 cycles -> pixel_data_1=0x01, pixel_data_2=0x00.
// - Rotation: from full load, 2 network shifts -> 0x03/0x02; 72 more shifts -> still 0x03/0x02.
// - Dual strobe: shift_SPI=shift_network=1 for one cycle with write_en=0 -> 0x04/0x03 (single recirculating shift).
// - Async reset mid-run: drop n_rst between clock edges -> outputs 0 immediately; with macro defined, position=0.

Source files
------------

// File: rtl/pixel_data.sv
// rtl/pixel_data.sv - DEPTH-entry circular byte ring between the SPI loader and the network reader.
// Optional shift position counter and wrap pulse under PIXEL_DATA_POSITION_EN.
module pixel_data #(
   parameter int DEPTH = 72,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     shift_SPI,
   input  logic                     shift_network,
   input  logic                     write_en,
   input  logic [WIDTH-1:0]         spi_in,
   output logic [WIDTH-1:0]         pixel_data_1,
   output logic [WIDTH-1:0]         pixel_data_2
`ifdef PIXEL_DATA_POSITION_EN
   ,
   output logic [$clog2(DEPTH)-1:0] position,
   output logic                     wrap
`endif
);

   logic             shift;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Both strobes together still advance the ring by a single entry.
   assign shift = shift_SPI | shift_network;

   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         mem_d[i] = shift ? mem_q[i+1] : mem_q[i];
      end
      mem_d[DEPTH-1] = mem_q[DEPTH-1];
      if (shift) begin
         mem_d[DEPTH-1] = write_en ? spi_in : mem_q[0];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign pixel_data_1 = mem_q[1];
   assign pixel_data_2 = mem_q[0];

`ifdef PIXEL_DATA_POSITION_EN
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] position_q, position_d;
   logic          wrap_q, wrap_d;
   logic          at_last;

   assign at_last = (position_q == PW'(DEPTH - 1));

   always_comb begin
      position_d = position_q;
      wrap_d     = 1'b0;
      if (shift) begin
         position_d = at_last ? '0 : position_q + PW'(1);
         wrap_d     = at_last;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         position_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         position_q <= position_d;
         wrap_q     <= wrap_d;
      end
   end

   assign position = position_q;
   assign wrap     = wrap_q;
`endif

endmodule

// File: tb/tb_pixel_data.sv
// tb/tb_pixel_data.sv - Directed and randomized checks of pixel_data against a queue model.
module tb_pixel_data;
   localparam int DEPTH = 72;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             shift_SPI = 1'b0;
   logic             shift_network = 1'b0;
   logic             write_en = 1'b0;
   logic [WIDTH-1:0] spi_in = '0;
   logic [WIDTH-1:0] pixel_data_1;
   logic [WIDTH-1:0] pixel_data_2;
`ifdef PIXEL_DATA_POSITION_EN
   logic [$clog2(DEPTH)-1:0] position;
   logic                     wrap;
`endif

   pixel_data #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .shift_SPI    (shift_SPI),
      .shift_network(shift_network),
      .write_en     (write_en),
      .spi_in       (spi_in),
      .pixel_data_1 (pixel_data_1),
      .pixel_data_2 (pixel_data_2)
`ifdef PIXEL_DATA_POSITION_EN
      ,
      .position     (position),
      .wrap         (wrap)
`endif
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] ring [$];
   int               pos_m;
   bit               wrap_m;
   int               n_checks;
   int               n_errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ring.delete();
      for (int i = 0; i < DEPTH; i++) ring.push_back('0);
      pos_m  = 0;
      wrap_m = 1'b0;
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".p1"}, 32'(pixel_data_1), 32'(ring[1]));
      check({tag, ".p2"}, 32'(pixel_data_2), 32'(ring[0]));
`ifdef PIXEL_DATA_POSITION_EN
      check({tag, ".pos"}, 32'(position), 32'(pos_m));
      check({tag, ".wrap"}, 32'(wrap), 32'(wrap_m));
`endif
   endtask

   task automatic step(input bit s_spi, input bit s_net, input bit we, input logic [WIDTH-1:0] din);
      logic [WIDTH-1:0] nv;
      @(negedge clk);
      shift_SPI     = s_spi;
      shift_network = s_net;
      write_en      = we;
      spi_in        = din;
      @(posedge clk);
      if (s_spi || s_net) begin
         nv = we ? din : ring[0];
         void'(ring.pop_front());
         ring.push_back(nv);
         wrap_m = (pos_m == DEPTH - 1);
         pos_m  = (pos_m + 1) % DEPTH;
      end else begin
         wrap_m = 1'b0;
      end
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      #12;
      check_outs("reset");
      n_rst = 1'b1;

      for (int i = 0; i < 140; i++) step(0, 1, 1, 8'h00);
      check_outs("zero_fill");

      step(1, 0, 1, 8'hFF);
      step(1, 0, 1, 8'hAA);
      for (int i = 0; i < 70; i++) step(0, 1, 0, 8'h00);
      check_outs("two_byte");
      check("two_byte.p1_const", 32'(pixel_data_1), 32'hAA);
      check("two_byte.p2_const", 32'(pixel_data_2), 32'hFF);

      for (int i = 0; i < DEPTH; i++) step(1, 0, 1, WIDTH'(i));
      check("full_load.p1", 32'(pixel_data_1), 32'h01);
      check("full_load.p2", 32'(pixel_data_2), 32'h00);
      check_outs("full_load");

      step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      check("rot2.p1", 32'(pixel_data_1), 32'h03);
      check("rot2.p2", 32'(pixel_data_2), 32'h02);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
      check("rot74.p1", 32'(pixel_data_1), 32'h03);
      check("rot74.p2", 32'(pixel_data_2), 32'h02);
      check_outs("rot74");

      step(0, 0, 1, 8'h55);
      check_outs("we_alone");

      step(1, 1, 0, 8'h77);
      check("dual.p1", 32'(pixel_data_1), 32'h04);
      check("dual.p2", 32'(pixel_data_2), 32'h03);
      check_outs("dual");

      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), WIDTH'($urandom));
         check_outs("random");
      end

      for (int i = 0; i < 5; i++) step(1, 0, 1, WIDTH'(8'h10 + i));
      @(negedge clk);
      shift_network = 1'b1;
      #2;
      n_rst = 1'b0;
      model_reset();
      #1;
      check_outs("async_rst");
      @(posedge clk);
      #1;
      check_outs("rst_hold");
      @(negedge clk);
      shift_network = 1'b0;
      n_rst = 1'b1;
      step(1, 0, 1, 8'hC3);
      check_outs("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
